cordic_result_serializer: RTL and testbench



---
 rtl/cordic_result_serializer_if.sv | 27 ++
 rtl/cordic_result_serializer.sv | 148 ++++++++++++++
 tb/tb_cordic_result_serializer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cordic_result_serializer_if.sv
// Result/transmit bus of the CORDIC result serializer.
// Groups the core-side result handshake (res_*) and the host-side byte
// handshake (out_*, host_ack).
//   slave  : serializer side (accepts results, drives the byte bus)
//   master : core + host side (drives results and ack, observes the bus)
interface cordic_result_serializer_if #(
  parameter int WIDTH = 16
);
  logic             res_valid;
  logic [WIDTH-1:0] res_x;
  logic [WIDTH-1:0] res_y;
  logic             res_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             host_ack;

  modport slave (
    input  res_valid, res_x, res_y, host_ack,
    output res_ready, out_data, out_valid, out_last
  );

  modport master (
    output res_valid, res_x, res_y, host_ack,
    input  res_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/cordic_result_serializer.sv
// Transmit side of the byte-wide CORDIC pin interface.
// Result pairs (x, y) are queued in a DEPTH-entry FIFO and streamed out as
// 2*WIDTH/8-byte frames (x then y, each LSB byte first) using a four-phase
// valid/ack handshake with an off-chip host.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : result input (res_valid/res_x/res_y/res_ready) and byte
//               output (out_data/out_valid/out_last) plus async host_ack
//   busy      : frame in flight or FIFO non-empty
//   ovf       : sticky, a push was attempted while the FIFO was full
module cordic_result_serializer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  cordic_result_serializer_if.slave    bus,
  output logic                         busy,
  output logic                         ovf
);

  localparam int NBYTES = 2 * WIDTH / 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

  state_t                         state_q;
  logic [DEPTH-1:0][2*WIDTH-1:0]  mem_q;
  logic [PW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                  count_q, count_d;
  logic [SYNC_STAGES-1:0]         sync_q;
  logic [NBYTES-1:0][7:0]         frame_q, head;
  logic [IDX_W-1:0]               idx_q, idx_nxt;
  logic [7:0]                     out_data_q;
  logic                           out_valid_q, out_last_q, ovf_q;
  logic                           ack_s, empty, push, pop, last_byte, nxt_last;

  assign ack_s         = sync_q[SYNC_STAGES-1];
  assign empty         = (count_q == '0);
  // Ready comes from the registered count only: a pop this cycle frees
  // the slot for the next cycle, never combinationally.
  assign bus.res_ready = (count_q != CW'(DEPTH));
  assign push          = bus.res_valid && bus.res_ready;
  assign last_byte     = (idx_q == IDX_W'(NBYTES - 1));
  assign idx_nxt       = idx_q + IDX_W'(1);
  assign nxt_last      = (idx_nxt == IDX_W'(NBYTES - 1));
  // Pop when idle, or when the last byte of a frame has been released.
  assign pop           = !empty &&
                         ((state_q == IDLE) ||
                          (state_q == RELEASE && !ack_s && last_byte));
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Host ack crosses into clk through a plain flop chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.host_ack};
  end

  // Result FIFO; storage is not reset, only pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.res_y, bus.res_x};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (bus.res_valid && !bus.res_ready) ovf_q <= 1'b1;
  end

  // Handshake FSM; out_data/out_last only change when entering PRESENT
  // (out_last also clears on return to IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            frame_q     <= head;
            out_data_q  <= head[0];
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack_s) begin
            out_valid_q <= 1'b0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            if (!last_byte) begin
              idx_q       <= idx_nxt;
              out_data_q  <= frame_q[idx_nxt];
              out_last_q  <= nxt_last;
              out_valid_q <= 1'b1;
              state_q     <= PRESENT;
            end else if (pop) begin
              frame_q     <= head;
              out_data_q  <= head[0];
              idx_q       <= '0;
              out_last_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= PRESENT;
            end else begin
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != IDLE) || !empty;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_cordic_result_serializer.sv
module tb_cordic_result_serializer;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy, ovf;
  int   tests = 0;
  int   fails = 0;
  logic [8:0] sb[$];   // {last, data} expected per byte

  always #5 clk = ~clk;

  cordic_result_serializer_if #(.WIDTH(WIDTH)) bus();

  cordic_result_serializer #(.WIDTH(WIDTH), .DEPTH(2), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .ovf  (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one result for a cycle; acc is whether the bench expects it taken.
  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic acc);
    bus.res_valid = 1'b1;
    bus.res_x     = x;
    bus.res_y     = y;
    chk("res_ready", {31'd0, bus.res_ready}, {31'd0, acc});
    if (acc) begin
      sb.push_back({1'b0, x[7:0]});
      sb.push_back({1'b0, x[15:8]});
      sb.push_back({1'b0, y[7:0]});
      sb.push_back({1'b1, y[15:8]});
    end
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 60) begin tick(); n++; end
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic check_byte(input string tag);
    logic [8:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 9'bx;
    chk({tag, "_byte"}, {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
  endtask

  // Host model: ack 3 cycles after valid rises, release 3 cycles after it falls.
  task automatic host_byte(input string tag);
    int n;
    wait_valid(tag);
    check_byte(tag);
    repeat (3) tick();
    bus.host_ack = 1'b1;
    n = 0;
    while (bus.out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
    repeat (3) tick();
    bus.host_ack = 1'b0;
  endtask

  initial begin
    bus.res_valid = 1'b0;
    bus.res_x     = '0;
    bus.res_y     = '0;
    bus.host_ack  = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data",  {24'd0, bus.out_data}, 32'd0);
    chk("rst_last",  {31'd0, bus.out_last}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("rst_ready", {31'd0, bus.res_ready}, 32'd1);

    // Single frame, latency 2
    push(16'h1234, 16'hABCD, 1'b1);
    chk("lat_t1", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("lat_t2", {31'd0, bus.out_valid}, 32'd1);
    chk("busy_on", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) host_byte("f1");
    repeat (4) tick();
    chk("busy_off", {31'd0, busy}, 32'd0);
    chk("f1_sb", sb.size(), 32'd0);

    // Host stalled, three pushes back to back
    push(16'h0001, 16'h0002, 1'b1);
    push(16'h0003, 16'h0004, 1'b1);
    push(16'h0005, 16'h0006, 1'b1);
    chk("full_ready", {31'd0, bus.res_ready}, 32'd0);
    chk("full_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 12; i++) host_byte("f2");
    repeat (4) tick();
    chk("f2_sb", sb.size(), 32'd0);

    // Overflow: fourth push dropped, ovf sticky
    push(16'h0101, 16'h0202, 1'b1);
    push(16'h0303, 16'h0404, 1'b1);
    push(16'h0505, 16'h0606, 1'b1);
    push(16'hDEAD, 16'hDEAD, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    repeat (5) tick();
    chk("ovf_hold", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 12; i++) host_byte("f3");
    repeat (10) tick();
    chk("f3_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("f3_sb", sb.size(), 32'd0);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Ack in IDLE is ignored
    bus.host_ack = 1'b1;
    repeat (6) tick();
    chk("idle_ack_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_ack_data", {24'd0, bus.out_data}, 32'h06);
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    bus.host_ack = 1'b0;
    repeat (4) tick();

    // Ack held high during byte 1
    push(16'h1234, 16'hABCD, 1'b1);
    host_byte("f4b0");
    wait_valid("f4b1");
    check_byte("f4b1");
    bus.host_ack = 1'b1;
    tick();
    chk("hold_t1", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("hold_t2", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("hold_t3", {31'd0, bus.out_valid}, 32'd0);
    repeat (17) tick();
    chk("hold_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("hold_data", {24'd0, bus.out_data}, 32'h12);
    bus.host_ack = 1'b0;
    host_byte("f4b2");
    host_byte("f4b3");
    repeat (4) tick();
    chk("f4_sb", sb.size(), 32'd0);

    // Reset mid-frame with one pair queued
    push(16'h1111, 16'h2222, 1'b1);
    push(16'h3333, 16'h4444, 1'b1);
    host_byte("f5b0");
    host_byte("f5b1");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, bus.res_ready}, 32'd1);
    chk("mrst_ovf",   {31'd0, ovf}, 32'd0);
    repeat (3) tick();
    push(16'hBEEF, 16'h0F0F, 1'b1);
    for (int i = 0; i < 4; i++) host_byte("f6");
    repeat (10) tick();
    chk("f6_sb", sb.size(), 32'd0);
    chk("f6_idle", {31'd0, bus.out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
